mem_port_ctrl: RTL and testbench
================================

# mem_port_ctrl

Multi-cycle memory port controller between the processor's control FSM and a single shared instruction/data memory bus. It consumes the control unit's MemRead, MemWrite, IorD and IRWrite strobes. It runs a request/grant/read-valid handshake on the bus and latches fetched words into the instruction register (IR) or the memory data register (MDR). It raises `stall`, which freezes the control FSM's state register until the access completes.

## Interface
- `ADDR_W`, 32: byte-address width.
- `DATA_W`, 32: data width; addresses must be `DATA_W/8`-aligned.
- `TIMEOUT`, 64: maximum cycles spent in REQ+WAIT_R before abort; must be ≥2.
- `clk`  in  1  clock.
- `reset`  in  1  reset; asynchronous, active-high.
- `mem_read`  in  1  read strobe from control unit.
- `mem_write`  in  1  write strobe from control unit.
- `iord`  in  1  0 selects `pc` as address, 1 selects `alu_out`.
- `ir_write`  in  1  read data goes to IR (1) or MDR (0).
- `pc`  in  ADDR_W  program counter.
- `alu_out`  in  ADDR_W  ALUOut register (load/store address).
- `store_data`  in  DATA_W  B register (store data).
- `stall`  out  1  holds the control FSM while high.
- `ir`  out  DATA_W  instruction register.
- `mdr`  out  DATA_W  memory data register.
- `err`  out  1  one-cycle pulse on misalignment, read+write conflict, or timeout.
- `bus_req`  out  1  bus request.
- `bus_we`  out  1  write enable.
- `bus_addr`  out  ADDR_W  address.
- `bus_wdata`  out  DATA_W  write data.
- `bus_gnt`  in  1  request accepted this cycle.
- `bus_rvalid`  in  1  read data valid this cycle.
- `bus_rdata`  in  DATA_W  read data.

## Operation
- **States:** IDLE, REQ, WAIT_R, DONE.
- **IDLE:** an access is `mem_read ^ mem_write`.
  - Compute the address from `iord` and check alignment (low `log2(DATA_W/8)` bits zero).
  - Legal access: latch address, we, wdata and target (IR/MDR). Go to REQ.
  - Misaligned access, or both strobes set: pulse `err`, stay in IDLE, issue no bus activity.
- **REQ:** `bus_req`=1 with latched fields.
  - `bus_gnt` with write: go to DONE.
  - `bus_gnt` with read: if `bus_rvalid` in the same cycle, capture data and go to DONE; otherwise go to WAIT_R.
- **WAIT_R:** on `bus_rvalid`, capture `bus_rdata` into the target register and go to DONE.
- **DONE:** one cycle with `stall`=0 so the control FSM advances. Strobes still asserted this cycle are ignored. Return to IDLE.
- **Capture:** only the target register is written. The other register holds its value.
- **Timeout:** the counter clears on leaving IDLE and increments in REQ/WAIT_R. When it reaches `TIMEOUT`:
  - pulse `err`,
  - drop `bus_req`,
  - leave IR/MDR unchanged,
  - go to DONE.
- **Stray `bus_rvalid`:** ignored in IDLE, REQ-before-gnt and DONE.
- **`stall`:** combinational. It equals (IDLE & legal access) | REQ | WAIT_R.

## Timing
- **Reset values:**
  - state IDLE,
  - `stall`=0, `err`=0, `bus_req`=0, `bus_we`=0,
  - `bus_addr`=0, `bus_wdata`=0,
  - `ir`=32'h0000_0013 (NOP), `mdr`=0,
  - timeout counter 0.
- **Read, zero-wait bus** (`gnt` in first REQ cycle, `rvalid` next cycle):
  - cycle 0: IDLE, `stall`=1;
  - cycle 1: REQ;
  - cycle 2: WAIT_R, capture at clock edge;
  - cycle 3: DONE.
- **Read with gnt and rvalid together:** DONE in cycle 2.
- **Write:** REQ in cycle 1; DONE in cycle 2 when `gnt` arrives in cycle 1.
- **Bus hold:** `bus_addr`, `bus_we` and `bus_wdata` are registered and stay stable from REQ entry until `gnt`.
- **`ir`/`mdr`:** update at the clock edge where `rvalid` is sampled, and are visible in DONE.
- **`err`:** registered, high exactly one cycle after the triggering condition.
- **Reset mid-transaction:** immediately go to IDLE and take all reset values. A late `rvalid` after reset is ignored.

## Structure
- **Shared package `mem_port_pkg`:**
  - `mem_port_state_t` enum (IDLE, REQ, WAIT_R, DONE),
  - `NOP_INSN` = 32'h0000_0013,
  - error-cause localparams for debug.
- **Sub-module `mem_port_timer`:** a clear/enable/expire counter sized `$clog2(TIMEOUT+1)`.
- The control FSM's state register gains a hold input driven by `stall`.

## Test plan
- Fetch: `pc`=0x100, `iord`=0, `ir_write`=1, `gnt` immediate, `rvalid` one cycle later with 0x00A00093. Expect `bus_addr`=0x100, `ir`=0x00A00093 in DONE, `mdr` unchanged, `stall` high for 3 cycles.
- Load with gnt delayed 3 cycles and rvalid 2 later: `alu_out`=0x2004, data 0xDEADBEEF. Expect `bus_addr` stable until gnt, `mdr`=0xDEADBEEF, `ir` unchanged.
- Store: `alu_out`=0x3000, `store_data`=0x12345678, gnt immediate. Expect `bus_we`=1 with those values, DONE in cycle 2, no capture.
- Misaligned load at 0x2002, then `mem_read` and `mem_write` both high. Expect one `err` pulse each, `bus_req` never high, `stall` 0.
- `TIMEOUT`=8, read granted but `rvalid` never arrives. Expect `err` pulse, DONE after 8 cycles in REQ+WAIT_R, `mdr` unchanged, and a later stray `rvalid` ignored.
- Assert `reset` in WAIT_R. Expect immediate IDLE, `ir`=0x13, `mdr`=0, `bus_req`=0; a following `rvalid` causes no capture.

Source files
------------

// File: rtl/mem_port_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_pkg
// Description : Shared types and constants for the multi-cycle memory port
//               controller (state encoding, reset instruction, error causes).
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT_R = 2'd2,
        ST_DONE   = 2'd3
    } mem_port_state_t;

    // Reset value of the instruction register: addi x0, x0, 0
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    // Error cause codes, for debug visibility of why err pulsed
    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_CONFLICT = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/mem_port_timer.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_timer
// Description : Clear/enable/expire counter bounding the time a bus access
//               may spend waiting on grant and read data.
//   clk      in  clock
//   reset    in  asynchronous active-high reset
//   clr_i    in  synchronous clear (has priority over enable)
//   en_i     in  count enable
//   expire_o out high in the enabled cycle in which the count reaches TIMEOUT
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // The count held during an enabled cycle is the number of earlier waiting
    // cycles, so this cycle is the TIMEOUT-th one when it equals TIMEOUT-1.
    assign expire_o = en_i && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/mem_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_ctrl
// Description : Multi-cycle memory port controller. Turns the control unit's
//               MemRead/MemWrite/IorD/IRWrite strobes into a request/grant/
//               read-valid bus handshake, captures fetched words into IR or
//               MDR, and stalls the control FSM until the access completes.
//   clk, reset                     clock, asynchronous active-high reset
//   mem_read, mem_write            access strobes from the control unit
//   iord                           address select: 0 = pc, 1 = alu_out
//   ir_write                       read target: 1 = IR, 0 = MDR
//   pc, alu_out, store_data        address sources and store data
//   stall                          holds the control FSM while high
//   ir, mdr                        instruction / memory data registers
//   err                            one-cycle error pulse
//   bus_req/we/addr/wdata          bus request side
//   bus_gnt/rvalid/rdata           bus response side
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_ctrl
    import mem_port_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              iord,
    input  logic              ir_write,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] alu_out,
    input  logic [DATA_W-1:0] store_data,
    output logic              stall,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] mdr,
    output logic              err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(DATA_W / 8 - 1);

    mem_port_state_t   state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              tgt_ir_q, tgt_ir_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] w_addr;
    logic              w_access;
    logic              w_conflict;
    logic              w_misalign;
    logic              w_legal;
    logic              w_waiting;
    logic              w_expire;

    assign w_addr     = iord ? alu_out : pc;
    assign w_access   = mem_read ^ mem_write;
    assign w_conflict = mem_read & mem_write;
    assign w_misalign = (w_addr & ALIGN_MASK) != '0;
    assign w_legal    = w_access & ~w_misalign;
    assign w_waiting  = (state_q == ST_REQ) || (state_q == ST_WAIT_R);

    mem_port_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (state_q == ST_IDLE),
        .en_i     (w_waiting),
        .expire_o (w_expire)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        tgt_ir_d = tgt_ir_q;
        ir_d     = ir_q;
        mdr_d    = mdr_q;
        err_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_legal) begin
                    addr_d   = w_addr;
                    we_d     = mem_write;
                    wdata_d  = store_data;
                    tgt_ir_d = ir_write;
                    state_d  = ST_REQ;
                end else if (w_conflict || w_access) begin
                    // Rejected access (conflict or misaligned): no bus activity
                    err_d = 1'b1;
                end
            end
            ST_REQ: begin
                // Completing in the expiring cycle wins over the abort
                if (bus_gnt && (we_q || bus_rvalid)) begin
                    if (!we_q) begin
                        if (tgt_ir_q) ir_d  = bus_rdata;
                        else          mdr_d = bus_rdata;
                    end
                    state_d = ST_DONE;
                end else if (w_expire) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (bus_gnt) begin
                    state_d = ST_WAIT_R;
                end
            end
            ST_WAIT_R: begin
                if (bus_rvalid) begin
                    if (tgt_ir_q) ir_d  = bus_rdata;
                    else          mdr_d = bus_rdata;
                    state_d = ST_DONE;
                end else if (w_expire) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // One free cycle so the control FSM advances; strobes ignored
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            tgt_ir_q <= 1'b0;
            ir_q     <= DATA_W'(NOP_INSN);
            mdr_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            tgt_ir_q <= tgt_ir_d;
            ir_q     <= ir_d;
            mdr_q    <= mdr_d;
            err_q    <= err_d;
        end
    end

    // Combinational so the control FSM is frozen in the very cycle it asks
    assign stall     = ((state_q == ST_IDLE) && w_legal) || w_waiting;
    assign bus_req   = (state_q == ST_REQ);
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign ir        = ir_q;
    assign mdr       = mdr_q;
    assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_ctrl
// Description : Self-checking bench for mem_port_ctrl. Each access is
//               described at transaction level (grant delay, read-data delay)
//               and its expected stall length, request cycles, error pulse
//               and IR/MDR contents are derived arithmetically.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_ctrl;

    localparam int TO = 8;

    logic        clk;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic        iord;
    logic        ir_write;
    logic [31:0] pc;
    logic [31:0] alu_out;
    logic [31:0] store_data;
    logic        stall;
    logic [31:0] ir;
    logic [31:0] mdr;
    logic        err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] ir_m;
    logic [31:0] mdr_m;

    mem_port_ctrl #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .iord       (iord),
        .ir_write   (ir_write),
        .pc         (pc),
        .alu_out    (alu_out),
        .store_data (store_data),
        .stall      (stall),
        .ir         (ir),
        .mdr        (mdr),
        .err        (err),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_gnt    (bus_gnt),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One access. g = REQ cycles before the grant, r = cycles from grant to
    // read data (0 = same cycle). Inputs change on the falling edge and
    // outputs are sampled 1 time unit later.
    task automatic run_txn(input bit rd, input bit wr, input bit iord_v, input bit irw,
                           input logic [31:0] pc_v, input logic [31:0] alu_v,
                           input logic [31:0] sd, input logic [31:0] rdat,
                           input int g, input int r);
        logic [31:0] a;
        bit legal, ok, open_run;
        int total, done_c, ncyc, run, tot, reqs, errs, err_at, exp_req, exp_err_at;
        a        = iord_v ? alu_v : pc_v;
        legal    = (rd != wr) && (a[1:0] == 2'b00);
        total    = wr ? g + 1 : g + 1 + r;
        ok       = legal && (total <= TO);
        done_c   = !legal ? 0 : (ok ? total + 1 : TO + 1);
        exp_req  = !legal ? 0 : (ok ? g + 1 : ((g + 1 < TO) ? g + 1 : TO));
        exp_err_at = !legal ? 1 : (ok ? -1 : done_c);
        ncyc     = done_c + 3;
        run = 0; tot = 0; reqs = 0; errs = 0; err_at = -1; open_run = 1'b1;
        if (ok && rd) begin
            if (irw) ir_m = rdat;
            else     mdr_m = rdat;
        end
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (k == 0) begin
                iord = iord_v; ir_write = irw; pc = pc_v; alu_out = alu_v; store_data = sd;
            end
            if (legal ? (k <= done_c) : (k == 0)) begin
                mem_read = rd; mem_write = wr;
            end else begin
                mem_read = 1'b0; mem_write = 1'b0;
            end
            bus_gnt = legal && (k == g + 1);
            if (legal && rd && (k == g + 1 + r)) begin
                bus_rvalid = 1'b1; bus_rdata = rdat;
            end else if ((k >= 1 && k < g + 1) || k == done_c || k == done_c + 1) begin
                bus_rvalid = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
            end else begin
                bus_rvalid = 1'b0; bus_rdata = $urandom;
            end
            #1;
            if (stall === 1'b1 && open_run) run++;
            else open_run = 1'b0;
            if (stall === 1'b1) tot++;
            if (bus_req === 1'b1) begin
                reqs++;
                chk("bus_addr", bus_addr, a);
                chk("bus_we", {31'b0, bus_we}, {31'b0, wr});
                if (wr) chk("bus_wdata", bus_wdata, sd);
            end
            if (err === 1'b1) begin
                errs++; err_at = k;
            end
            if (legal && k == done_c) begin
                chk("ir_in_done", ir, ir_m);
                chk("mdr_in_done", mdr, mdr_m);
            end
        end
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        chk("stall_run", run, done_c);
        chk("stall_total", tot, done_c);
        chk("req_cycles", reqs, exp_req);
        chk("err_count", errs, (exp_err_at < 0) ? 0 : 1);
        chk("err_cycle", err_at, exp_err_at);
        chk("ir_end", ir, ir_m);
        chk("mdr_end", mdr, mdr_m);
    endtask

    initial begin
        int op, g, r;
        logic [31:0] a, other;
        bit io, irw, rd, wr;

        reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; iord = 1'b0; ir_write = 1'b0;
        pc = '0; alu_out = '0; store_data = '0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        ir_m = 32'h0000_0013; mdr_m = '0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_bus_req", {31'b0, bus_req}, 32'd0);
        chk("rst_bus_we", {31'b0, bus_we}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_ir", ir, 32'h0000_0013);
        chk("rst_mdr", mdr, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Fetch, grant at once, data one cycle later
        run_txn(1, 0, 0, 1, 32'h0000_0100, 32'h0, 32'h0, 32'h00A0_0093, 0, 1);
        // Load, grant after 3 cycles, data 2 cycles after grant
        run_txn(1, 0, 1, 0, 32'h0000_0104, 32'h0000_2004, 32'h0, 32'hDEAD_BEEF, 3, 2);
        // Store, grant at once
        run_txn(0, 1, 1, 0, 32'h0000_0108, 32'h0000_3000, 32'h1234_5678, 32'h0, 0, 0);
        // Misaligned load, then read+write conflict
        run_txn(1, 0, 1, 0, 32'h0000_010C, 32'h0000_2002, 32'h0, 32'h5555_AAAA, 0, 1);
        run_txn(1, 1, 1, 0, 32'h0000_010C, 32'h0000_2008, 32'h0, 32'h5555_AAAA, 0, 1);
        // Read granted, data never arrives in time
        run_txn(1, 0, 1, 0, 32'h0000_0110, 32'h0000_4000, 32'h0, 32'hCAFE_F00D, 0, 50);
        // Read with grant and data together
        run_txn(1, 0, 1, 1, 32'h0000_0114, 32'h0000_5000, 32'h0, 32'h0BAD_F00D, 1, 0);

        // Reset while waiting for read data
        @(negedge clk);
        iord = 1'b0; pc = 32'h0000_0200; ir_write = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
        #1 chk("rstwr_idle_stall", {31'b0, stall}, 32'd1);
        @(negedge clk);
        bus_gnt = 1'b1;
        #1 chk("rstwr_req", {31'b0, bus_req}, 32'd1);
        @(negedge clk);
        bus_gnt = 1'b0;
        #1 chk("rstwr_wait_stall", {31'b0, stall}, 32'd1);
        chk("rstwr_wait_req", {31'b0, bus_req}, 32'd0);
        reset = 1'b1; mem_read = 1'b0;
        #1;
        chk("rstwr_stall", {31'b0, stall}, 32'd0);
        chk("rstwr_bus_req", {31'b0, bus_req}, 32'd0);
        chk("rstwr_ir", ir, 32'h0000_0013);
        chk("rstwr_mdr", mdr, 32'd0);
        chk("rstwr_bus_addr", bus_addr, 32'd0);
        ir_m = 32'h0000_0013; mdr_m = '0;
        @(negedge clk);
        reset = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        bus_rvalid = 1'b0;
        #1;
        chk("late_rvalid_ir", ir, ir_m);
        chk("late_rvalid_mdr", mdr, mdr_m);
        chk("late_rvalid_stall", {31'b0, stall}, 32'd0);

        // Randomized accesses
        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 5);
            g  = $urandom_range(0, 4);
            r  = $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) r = 12;
            if ($urandom_range(0, 9) == 0) g = 9;
            a     = $urandom & 32'hFFFF_FFFC;
            other = $urandom;
            io    = 1'($urandom_range(0, 1));
            irw   = 1'($urandom_range(0, 1));
            rd = 1'b1; wr = 1'b0;
            case (op)
                3: begin rd = 1'b0; wr = 1'b1; end
                4: begin
                    a = a | 32'($urandom_range(1, 3));
                    if ($urandom_range(0, 1) == 1) begin rd = 1'b0; wr = 1'b1; end
                end
                5: begin rd = 1'b1; wr = 1'b1; end
                default: ;
            endcase
            if (io) run_txn(rd, wr, io, irw, other, a, $urandom, $urandom, g, r);
            else    run_txn(rd, wr, io, irw, a, other, $urandom, $urandom, g, r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
